// File: rtl/conv_same_ctrl_pkg.sv
// Shared widths, FSM state encoding and the index incrementer for the
// "same"-mode convolution sequencer.
package conv_same_ctrl_pkg;

    localparam int DATA_W = 8;
    localparam int IDX_W  = 5;
    localparam int ACC_W  = 2*DATA_W + IDX_W;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CALC  = 3'd1,
        ISSUE = 3'd2,
        DRAIN = 3'd3,
        WRITE = 3'd4,
        DONE  = 3'd5
    } state_t;

    function automatic logic [IDX_W-1:0] same_i(input logic [IDX_W-1:0] v);
        return v + IDX_W'(1);
    endfunction

endpackage

// File: rtl/conv_same_bounds.sv
// Valid product-term range for one centred output: kmin..kmax, with m = n + off.
module conv_same_bounds
    import conv_same_ctrl_pkg::*;
(
    input  logic [IDX_W-1:0] i_n,
    input  logic [IDX_W-1:0] i_off,
    input  logic [IDX_W-1:0] i_size_x,
    input  logic [IDX_W-1:0] i_size_y,
    output logic [IDX_W-1:0] o_kmin,
    output logic [IDX_W-1:0] o_kmax,
    output logic [IDX_W:0]   o_m
);

    logic [IDX_W-1:0] w_sx1;
    logic [IDX_W-1:0] w_sy1;
    logic [IDX_W:0]   w_m;

    // m can exceed 31 (n up to 30 plus off up to 15), hence the extra bit.
    assign w_m   = {1'b0, i_n} + {1'b0, i_off};
    assign w_sx1 = i_size_x - IDX_W'(1);
    assign w_sy1 = i_size_y - IDX_W'(1);
    assign o_m   = w_m;

    always_comb begin
        o_kmin = '0;
        o_kmax = w_sx1;
        if (w_m > {1'b0, w_sy1}) begin
            o_kmin = IDX_W'(w_m - {1'b0, w_sy1});
        end
        if (w_m < {1'b0, w_sx1}) begin
            o_kmax = w_m[IDX_W-1:0];
        end
    end

endmodule

// File: rtl/conv_same_ctrl.sv
// "Same"-mode convolution sequencer: issues X/Y read pairs per output,
// accumulates returned products and writes one centred result per output to Z.
//   state | meaning
//   IDLE  | waiting for start, outputs quiet
//   CALC  | load k range for output n, clear accumulator
//   ISSUE | one X/Y read per cycle, k = kmin..kmax
//   DRAIN | last read data returns and is accumulated
//   WRITE | Z[n] <= acc
//   DONE  | one-cycle done pulse
module conv_same_ctrl
    import conv_same_ctrl_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [IDX_W-1:0]  i_size_x,
    input  logic [IDX_W-1:0]  i_size_y,
    output logic [IDX_W-1:0]  o_mem_x_addr,
    output logic [IDX_W-1:0]  o_mem_y_addr,
    output logic              o_mem_rd,
    input  logic [DATA_W-1:0] i_mem_x_data,
    input  logic [DATA_W-1:0] i_mem_y_data,
    output logic [IDX_W-1:0]  o_mem_z_addr,
    output logic [ACC_W-1:0]  o_mem_z_data,
    output logic              o_mem_z_we,
    output logic              o_busy,
    output logic              o_done
);

    state_t           r_state;
    logic [IDX_W-1:0] r_size_x;
    logic [IDX_W-1:0] r_size_y;
    logic [IDX_W-1:0] r_n;
    logic [IDX_W-1:0] r_k;
    logic [IDX_W-1:0] r_ym;
    logic [IDX_W-1:0] r_kmax;
    logic [ACC_W-1:0] r_acc;
    logic             r_rd_valid;

    logic [IDX_W-1:0]    w_off;
    logic [IDX_W-1:0]    w_kmin;
    logic [IDX_W-1:0]    w_kmax;
    logic [IDX_W:0]      w_m;
    logic [2*DATA_W-1:0] w_prod;
    logic                w_issue;
    logic                w_write;

    assign w_off  = (r_size_y - IDX_W'(1)) >> 1;
    assign w_prod = i_mem_x_data * i_mem_y_data;

    conv_same_bounds u_bounds (
        .i_n      (r_n),
        .i_off    (w_off),
        .i_size_x (r_size_x),
        .i_size_y (r_size_y),
        .o_kmin   (w_kmin),
        .o_kmax   (w_kmax),
        .o_m      (w_m)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_size_x   <= '0;
            r_size_y   <= '0;
            r_n        <= '0;
            r_k        <= '0;
            r_ym       <= '0;
            r_kmax     <= '0;
            r_acc      <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            // Read data lands one cycle after the strobe; add it at the end of that cycle.
            r_rd_valid <= (r_state == ISSUE);
            if (r_rd_valid) begin
                r_acc <= r_acc + ACC_W'(w_prod);
            end
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_size_x <= i_size_x;
                        r_size_y <= i_size_y;
                        r_n      <= '0;
                        if (i_size_x == '0 || i_size_y == '0) begin
                            r_state <= DONE;
                        end else begin
                            r_state <= CALC;
                        end
                    end
                end
                CALC: begin
                    r_k     <= w_kmin;
                    r_ym    <= IDX_W'(w_m - {1'b0, w_kmin});
                    r_kmax  <= w_kmax;
                    r_acc   <= '0;
                    r_state <= ISSUE;
                end
                ISSUE: begin
                    if (r_k == r_kmax) begin
                        r_state <= DRAIN;
                    end else begin
                        r_k  <= same_i(r_k);
                        r_ym <= r_ym - IDX_W'(1);
                    end
                end
                DRAIN: begin
                    r_state <= WRITE;
                end
                WRITE: begin
                    if (r_n == r_size_x - IDX_W'(1)) begin
                        r_state <= DONE;
                    end else begin
                        r_n     <= same_i(r_n);
                        r_state <= CALC;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Outputs decode registered state only; addresses/data are forced to 0 when not in use.
    assign w_issue      = (r_state == ISSUE);
    assign w_write      = (r_state == WRITE);
    assign o_mem_rd     = w_issue;
    assign o_mem_x_addr = w_issue ? r_k  : '0;
    assign o_mem_y_addr = w_issue ? r_ym : '0;
    assign o_mem_z_we   = w_write;
    assign o_mem_z_addr = w_write ? r_n   : '0;
    assign o_mem_z_data = w_write ? r_acc : '0;
    assign o_busy       = (r_state == CALC) || w_issue || (r_state == DRAIN) || w_write;
    assign o_done       = (r_state == DONE);

endmodule

// File: doc/conv_same_ctrl.md
# conv_same_ctrl

Sequencer for the convolution core's "same" mode. It walks output index n over 0..size_x-1 and, for each n, issues the X/Y memory address pairs of every valid product term. It accumulates the returned products and writes one centred result per output to the Z memory. It sits between the host start/size registers and the X, Y and Z synchronous RAMs, and replaces free-running index logic with a single controlled schedule.

## Interface
- DATA_W, 8, width of X and Y samples (unsigned)
- IDX_W, 5, width of lengths and indexes (max length 2^IDX_W-1 = 31)
- ACC_W, 2*DATA_W+IDX_W (21), accumulator and Z data width
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- size_x  in  IDX_W  length of X (0..31); latched on accepted start
- size_y  in  IDX_W  length of Y (0..31); latched on accepted start
- mem_x_addr  out  IDX_W  X read address
- mem_y_addr  out  IDX_W  Y read address
- mem_rd  out  1  read strobe for X and Y
- mem_x_data  in  DATA_W  X read data, valid 1 cycle after mem_rd
- mem_y_data  in  DATA_W  Y read data, valid 1 cycle after mem_rd
- mem_z_addr  out  IDX_W  Z write address (= n)
- mem_z_data  out  ACC_W  Z write data
- mem_z_we  out  1  Z write enable, one cycle per output
- busy  out  1  high in CALC/ISSUE/DRAIN/WRITE
- done  out  1  one-cycle pulse at end of job

## Operation
- off = (size_y-1)>>1, computed from latched sizes; m = n + off.
- For output n, the valid k range is kmin = max(0, m-(size_y-1)) to kmax = min(m, size_x-1).
- The term count is L = kmax-kmin+1, always ≥1 for nonzero sizes.
- Each term reads x[k] at mem_x_addr=k and y[m-k] at mem_y_addr=m-k.
- Result: Z[n] = Σ x[k]·y[m-k]. Products are DATA_W×DATA_W unsigned, zero-extended to ACC_W. No saturation is needed: 31·255² < 2^21.
- FSM states:
  - IDLE: outputs 0. On start, latch sizes. If either size is 0, go to DONE; otherwise n←0 and go to CALC.
  - CALC (1 cycle): compute kmin/kmax for n, k←kmin, acc←0.
  - ISSUE (L cycles): mem_rd=1 with addresses for k; k++. Leave after issuing kmax.
  - DRAIN (1 cycle): the last read data returns and is accumulated.
  - WRITE (1 cycle): mem_z_we=1, mem_z_addr=n, mem_z_data=acc. If n==size_x-1, go to DONE; else n←n+1 and go to CALC.
  - DONE (1 cycle): done=1, busy=0, then IDLE.
- Accumulate: a registered rd_valid (mem_rd delayed 1 cycle) gates acc ← acc + x·y at the edge ending the data-return cycle.
- start while not IDLE is ignored. Size inputs are don't-care except at an accepted start.
- rst in any state: state←IDLE, n/k/acc←0, all outputs 0 on the next cycle, no partial write. An in-flight read return is discarded.

## Timing
- Reset values: mem_* addresses and data 0, mem_rd 0, mem_z_we 0, busy 0, done 0.
- Outputs are registered or decoded from registered state only; no combinational path from inputs to outputs.
- Start accepted in cycle t means CALC in t+1, busy high from t+1.
- Per output: 1 (CALC) + L (ISSUE) + 1 (DRAIN) + 1 (WRITE) = L+3 cycles.
- Read data must be valid exactly 1 cycle after mem_rd. mem_rd is never asserted back-to-back across outputs because CALC/DRAIN/WRITE separate the bursts.
- done rises the cycle after the last WRITE. A new start is accepted at the earliest in the IDLE cycle that follows.

## Structure
- Shared package/header holds DATA_W, IDX_W, ACC_W defaults and the state encodings (IDLE, CALC, ISSUE, DRAIN, WRITE, DONE).
- The n counter increment reuses the existing 5-bit index incrementer same_i.
- kmin/kmax computation is a natural small combinational sub-module, conv_same_bounds (inputs n, off, size_x, size_y; outputs kmin, kmax, m).
- The FSM, k counter and accumulator stay in the top.

## Test plan
- X=[1,2,3], Y=[1,1,1], sizes 3/3 -> Z=[3,6,5] at addresses 0..2; L=2,3,2; done 16 cycles after CALC entry.
- X=[1,2,3,4], Y=[1,1], sizes 4/2 (off=0) -> Z=[1,3,5,7]. Check address pairs for n=1: (0,1),(1,0).
- X=[5,6,7], Y=[2], sizes 3/1 -> Z=[10,12,14]. Each output takes 4 cycles; mem_z_we pulses exactly 3 times.
- size_x=31, size_y=31, all samples 255 -> Z[15]=31·65025=2015775 with no overflow. Z[0]=16·65025=1040400.
- start pulsed during ISSUE -> ignored, results unchanged. size_x=0 -> done the cycle after IDLE→DONE, zero writes, busy never high.
- rst asserted in the middle of ISSUE of n=1 -> next cycle all outputs 0 and state IDLE. A subsequent start then produces the full correct result set.
